// File: rtl/ball_recv_controller.sv
// Receive-side ball packet assembler: collects header, y low, vy and checksum
// bytes from the I2C slave, and publishes validated ball position/velocity.
module ball_recv_controller #(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [5:0]  HEADER         = 6'b101101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       bus_stop,
  output logic [9:0] o_ball_y,
  output logic [7:0] o_ball_vy,
  output logic       ball_recv_valid,
  output logic       frame_err,
  output logic       is_receiving
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Abort fires on the edge where the gap timer would reach TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] EXPIRE = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_YLO, GOT_VY} state_t;

  state_t        state, next_state;
  logic [TW-1:0] timer;
  logic [1:0]    y_hi;
  logic [7:0]    y_lo;
  logic [7:0]    vy_stage;
  logic [7:0]    csum;
  logic          err_d, ok_d, ld_hdr, ld_ylo, ld_vy;

  always_comb begin
    next_state = state;
    err_d      = 1'b0;
    ok_d       = 1'b0;
    ld_hdr     = 1'b0;
    ld_ylo     = 1'b0;
    ld_vy      = 1'b0;
    if (rx_valid) begin
      unique case (state)
        IDLE: begin
          if (rx_data[7:2] == HEADER) begin
            ld_hdr     = 1'b1;
            next_state = GOT_HDR;
          end else begin
            err_d = 1'b1;
          end
        end
        GOT_HDR: begin
          ld_ylo     = 1'b1;
          next_state = GOT_YLO;
        end
        GOT_YLO: begin
          ld_vy      = 1'b1;
          next_state = GOT_VY;
        end
        GOT_VY: begin
          ok_d       = (rx_data == csum);
          err_d      = (rx_data != csum);
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
    // A byte that leaves the packet open can still be aborted by stop/timeout;
    // a byte that closes it has already produced its single strobe.
    if (next_state != IDLE && (bus_stop || (!rx_valid && timer == EXPIRE))) begin
      err_d      = 1'b1;
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      timer           <= '0;
      y_hi            <= '0;
      y_lo            <= '0;
      vy_stage        <= '0;
      csum            <= '0;
      o_ball_y        <= '0;
      o_ball_vy       <= '0;
      ball_recv_valid <= 1'b0;
      frame_err       <= 1'b0;
      is_receiving    <= 1'b0;
    end else begin
      state           <= next_state;
      timer           <= (next_state == IDLE || rx_valid) ? '0 : timer + 1'b1;
      ball_recv_valid <= ok_d;
      frame_err       <= err_d;
      is_receiving    <= (next_state != IDLE);
      if (ld_hdr) begin
        y_hi <= rx_data[1:0];
        csum <= rx_data;
      end
      if (ld_ylo) begin
        y_lo <= rx_data;
        csum <= csum ^ rx_data;
      end
      if (ld_vy) begin
        vy_stage <= rx_data;
        csum     <= csum ^ rx_data;
      end
      if (ok_d) begin
        o_ball_y  <= {y_hi, y_lo};
        o_ball_vy <= vy_stage;
      end
    end
  end

endmodule

// File: tb/tb_ball_recv_controller.sv
// Bench for ball_recv_controller: directed packets plus random traffic, checked
// by a packet-level reference model through an expected-event queue.
module tb_ball_recv_controller;

  localparam int         T   = 16;
  localparam logic [5:0] HDR = 6'b101101;
  localparam int         W   = 51; // {cycle[31:0], err, y[9:0], vy[7:0]}

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       bus_stop = 1'b0;
  logic [9:0] o_ball_y;
  logic [7:0] o_ball_vy;
  logic       ball_recv_valid;
  logic       frame_err;
  logic       is_receiving;

  ball_recv_controller #(.TIMEOUT_CYCLES(T), .HEADER(HDR)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .bus_stop(bus_stop), .o_ball_y(o_ball_y), .o_ball_vy(o_ball_vy),
    .ball_recv_valid(ball_recv_valid), .frame_err(frame_err),
    .is_receiving(is_receiving)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // reference model: bytes of the open packet, idle edges since last byte, last good values
  logic [W-1:0] exp_q[$];
  logic [7:0]   pkt[$];
  int           gap = 0;
  logic [9:0]   last_y = '0;
  logic [7:0]   last_vy = '0;
  logic         exp_recv = 1'b0;

  function automatic void push_evt(int tag, logic err);
    exp_q.push_back({tag[31:0], err, last_y, last_vy});
  endfunction

  // One clock of stimulus; the model predicts the strobe seen after this edge.
  task automatic step(input logic v, input logic [7:0] d, input logic s);
    int   tag;
    logic sum_ok;
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    bus_stop = s;
    tag = cyc + 1;
    if (v) begin
      gap = 0;
      if (pkt.size() == 0) begin
        if (d[7:2] == HDR) pkt.push_back(d);
        else push_evt(tag, 1'b1);
      end else begin
        pkt.push_back(d);
        if (pkt.size() == 4) begin
          sum_ok = ((pkt[0] ^ pkt[1] ^ pkt[2]) == pkt[3]);
          if (sum_ok) begin
            last_y  = {pkt[0][1:0], pkt[1]};
            last_vy = pkt[2];
          end
          push_evt(tag, !sum_ok);
          pkt.delete();
        end
      end
      if (s && pkt.size() > 0) begin
        push_evt(tag, 1'b1);
        pkt.delete();
      end
    end else if (pkt.size() > 0) begin
      gap++;
      if (s || gap == T - 1) begin
        push_evt(tag, 1'b1);
        pkt.delete();
      end
    end
    @(posedge clk);
    exp_recv = (pkt.size() > 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_pkt(input logic [9:0] y, input logic [7:0] vy,
                          input logic [7:0] corrupt, input int max_gap);
    logic [7:0] b[4];
    b[0] = {HDR, y[9:8]};
    b[1] = y[7:0];
    b[2] = vy;
    b[3] = b[0] ^ b[1] ^ b[2] ^ corrupt;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, b[i], 1'b0);
      if (max_gap > 0 && i < 3) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    rx_valid = 1'b0;
    bus_stop = 1'b0;
    pkt.delete();
    gap = 0;
    last_y = '0;
    last_vy = '0;
    exp_recv = 1'b0;
    @(posedge clk);
    #1;
    check("reset_y", o_ball_y, 10'd0);
    check("reset_vy", o_ball_vy, 8'd0);
    check("reset_valid", ball_recv_valid, 1'b0);
    check("reset_err", frame_err, 1'b0);
    check("reset_recv", is_receiving, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // monitor / scoreboard
  logic [W-1:0] e;
  always @(negedge clk) begin
    if (!reset) begin
      if (ball_recv_valid || frame_err) begin
        check("strobe_exclusive", {ball_recv_valid, frame_err}, {~frame_err, ~ball_recv_valid});
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {frame_err, o_ball_y, o_ball_vy}, 64'hdead);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", 64'(cyc), 64'(e[50:19]));
          check("event_value", {frame_err, o_ball_y, o_ball_vy}, e[18:0]);
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][50:19]) <= cyc) begin
        e = exp_q.pop_front();
        check("missing_strobe", 64'(cyc), 64'hFFFF_FFFF);
      end
      check("is_receiving", is_receiving, exp_recv);
    end
  end

  initial begin
    int kind;
    do_reset();
    // good packet, then bad checksum keeps previous values
    send_pkt(10'h2A5, 8'h13, 8'h00, 0);
    idle(2);
    send_pkt(10'h2A5, 8'h13, 8'h01, 0);
    idle(2);
    // header mismatch, then good packet
    step(1'b1, 8'h00, 1'b0);
    idle(2);
    send_pkt(10'h155, 8'hC3, 8'h00, 0);
    // timeout after two bytes
    step(1'b1, 8'hB6, 1'b0);
    step(1'b1, 8'hA5, 1'b0);
    idle(20);
    send_pkt(10'h0FF, 8'h80, 8'h00, 0);
    // stop abort, then stop coincident with checksum
    step(1'b1, 8'hB6, 1'b0);
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hB7, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'hB7 ^ 8'h11 ^ 8'h22, 1'b1);
    idle(2);
    // stop with a rejected header, and stop while idle
    step(1'b1, 8'h55, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    // reset mid-packet, then back-to-back packets
    step(1'b1, 8'hB6, 1'b0);
    do_reset();
    send_pkt(10'h2A5, 8'h13, 8'h00, 0);
    send_pkt(10'h3FF, 8'hFF, 8'h00, 0);
    send_pkt(10'h000, 8'h00, 8'h00, 0);
    idle(2);
    // random traffic
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: send_pkt(10'($urandom), 8'($urandom), 8'h00, $urandom_range(0, 3));
        4: send_pkt(10'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), 1);
        5: step(1'b1, 8'($urandom), 1'b0);
        6: begin
          step(1'b1, {HDR, 2'($urandom)}, 1'b0);
          idle($urandom_range(0, 3));
          step(1'b0, 8'h00, 1'b1);
        end
        7: begin
          step(1'b1, {HDR, 2'($urandom)}, 1'b0);
          idle($urandom_range(T - 3, T + 2));
        end
        8: step(1'b1, 8'($urandom), 1'($urandom));
        default: idle($urandom_range(0, 4));
      endcase
    end
    idle(T + 2);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ball_recv_controller.md
# ball_recv_controller

Receive-side counterpart of the ball send path. Sits behind the I2C slave byte interface on the receiving board, assembles the 4-byte ball packet (header+y high bits, y low byte, vy, checksum) into a validated ball position/velocity, and presents it to the game logic with a one-cycle valid strobe. Malformed, truncated or stalled packets are dropped with a one-cycle error strobe; the last good values are held otherwise.

## Interface
- TIMEOUT_CYCLES, 100000: max idle clocks between bytes of one packet before abort (≥2).
- HEADER, 6'b101101: fixed tag in byte0[7:2].

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received I2C byte.
- rx_data  in  8  received byte, valid only with rx_valid.
- bus_stop  in  1  one-cycle strobe on I2C STOP condition.
- o_ball_y  out  10  last accepted ball y.
- o_ball_vy  out  8  last accepted ball vy.
- ball_recv_valid  out  1  one-cycle strobe: o_ball_y/o_ball_vy just updated.
- frame_err  out  1  one-cycle strobe: packet discarded.
- is_receiving  out  1  high while a packet is partially received (state ≠ IDLE).

Reset: reset reset, asynchronous, active-high; clock clk.

## Operation
- Packet: byte0 = {HEADER, y[9:8]}, byte1 = y[7:0], byte2 = vy, byte3 = byte0 ^ byte1 ^ byte2.
- FSM states: IDLE, GOT_HDR, GOT_YLO, GOT_VY.
  - IDLE + rx_valid: if rx_data[7:2]==HEADER, store y[9:8], running xor = rx_data, → GOT_HDR; else frame_err, stay IDLE.
  - GOT_HDR + rx_valid: store y[7:0], xor ^= rx_data, → GOT_YLO.
  - GOT_YLO + rx_valid: store vy, xor ^= rx_data, → GOT_VY.
  - GOT_VY + rx_valid: if rx_data == xor, load o_ball_y/o_ball_vy from staging regs and pulse ball_recv_valid; else pulse frame_err, outputs unchanged. Both → IDLE.
- Staging registers are separate from outputs; outputs change only on a good checksum.
- Gap timer: cleared on every rx_valid and in IDLE; increments each clock in non-IDLE states. Reaching TIMEOUT_CYCLES−1 with no rx_valid: frame_err, → IDLE.
- bus_stop in non-IDLE: frame_err, → IDLE. bus_stop in IDLE: ignored.
- Simultaneous rx_valid and bus_stop: byte is processed first; if the resulting state is IDLE (packet completed or header rejected) stop has no further effect; otherwise stop aborts with one frame_err (never two errors in one cycle).
- Simultaneous rx_valid and timeout expiry: rx_valid wins, timer clears.
- Bytes beyond byte3 within the same transaction are treated as a new packet header.

## Timing
- Reset values: o_ball_y=0, o_ball_vy=0, ball_recv_valid=0, frame_err=0, is_receiving=0, state IDLE, timer 0, staging 0.
- Reset mid-packet: partial packet discarded, no error strobe.
- Latency: checksum byte rx_valid at edge N → o_ball_* updated and ball_recv_valid high during cycle N+1, low at N+2.
- frame_err registered: high for exactly the cycle after the offending event.
- ball_recv_valid and frame_err never high in the same cycle.
- is_receiving registered from state; rises the cycle after a good header, falls the cycle after return to IDLE.
- Back-to-back rx_valid every clock supported (4-cycle packet minimum).

## Test plan
- Good packet: bytes 0xB6,0xA5,0x13,0x00 (y=0x2A5, vy=0x13) → o_ball_y=0x2A5, o_ball_vy=0x13, ball_recv_valid single pulse one cycle after byte3, frame_err never.
- Bad checksum: 0xB6,0xA5,0x13,0x01 after a good packet → one frame_err, outputs stay at previous values, no valid.
- Header mismatch: byte 0x00 in IDLE → frame_err pulse, is_receiving stays 0; then good packet still accepted.
- Timeout (TIMEOUT_CYCLES=16): 0xB6,0xA5 then silence → frame_err exactly 15 clocks after 0xA5's rx_valid, is_receiving falls; following good packet accepted.
- Stop abort: 0xB6,0xA5 then bus_stop → frame_err; bus_stop coincident with checksum byte of a good packet → valid pulse, no frame_err.
- Reset mid-packet after 0xB6 → all outputs 0, no strobes; next good packet accepted normally; two back-to-back good packets at one byte per clock → two valid pulses 4 cycles apart.
